// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ requesters,
// sending each posted 16-bit word as two bytes (high first) with a per-byte watchdog.
`timescale 1ns/1ps

module uart_tx_sched #(
    parameter int NUM_REQ   = 4,
    parameter int TO_CYCLES = 32768
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    ack,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  busy,
    output logic                  timeout,
    output logic                  trmt,
    output logic [7:0]            tx_data,
    input  logic                  tx_done,
    output logic [2:0]            fsm_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TO_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TO_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_HI = 3'd1,
        WAIT_HI = 3'd2,
        SEND_LO = 3'd3,
        WAIT_LO = 3'd4
    } state_t;

    // Handshake: trmt is a one-cycle start strobe; the transmitter answers with
    // tx_done, which is only looked at while waiting on the byte just started.
    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [7:0]       lo_byte;
    logic [WD_W-1:0]  wd;

    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [15:0]      pick_word;
    logic [PTR_W-1:0] next_ptr;
    logic             wait_state;
    logic             wd_expired;

    // Scan from the highest offset down so the closest requester at or above
    // rr_ptr is the last (winning) assignment.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_word  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int j;
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[j]) begin
                pick_valid = 1'b1;
                pick_idx   = PTR_W'(j);
                pick_word  = req_data[16*j +: 16];
            end
        end
    end

    assign next_ptr   = (owner == PTR_TOP) ? '0 : owner + PTR_W'(1);
    assign wait_state = (state == WAIT_HI) || (state == WAIT_LO);
    assign wd_expired = (wd == WD_LAST);

    // ack and timeout must land in the same cycle the completing tx_done is seen,
    // while grant is still held, so they are decoded from the registered state.
    assign ack       = (state == WAIT_LO && tx_done) ? grant : '0;
    assign timeout   = wait_state && !tx_done && wd_expired;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            lo_byte <= 8'h00;
            wd      <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            trmt    <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            trmt <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= SEND_HI;
                        owner   <= pick_idx;
                        lo_byte <= pick_word[7:0];
                        grant   <= NUM_REQ'(1) << pick_idx;
                        busy    <= 1'b1;
                        trmt    <= 1'b1;
                        tx_data <= pick_word[15:8];
                    end
                end
                SEND_HI: begin
                    state <= WAIT_HI;
                    wd    <= '0;
                end
                WAIT_HI: begin
                    if (tx_done) begin
                        state   <= SEND_LO;
                        trmt    <= 1'b1;
                        tx_data <= lo_byte;
                    end else if (wd_expired) begin
                        state  <= IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                SEND_LO: begin
                    state <= WAIT_LO;
                    wd    <= '0;
                end
                WAIT_LO: begin
                    // Completion and abort both release the bus and advance the pointer.
                    if (tx_done || wd_expired) begin
                        state  <= IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> $onehot(grant));
    a_grant_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !busy |-> (grant == '0));
    a_trmt_busy: assert property (@(posedge clk) disable iff (!rst_n)
        trmt |-> busy);
    a_ack_single: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(ack) && !(timeout && (ack != '0)));

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a behavioural UART stub, requester driver
// and a message-level reference model with an expected-byte queue.
`timescale 1ns/1ps

module tb_uart_tx_sched;

    localparam int NR = 4;
    localparam int TO = 32768;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [16*NR-1:0] req_data;
    logic [NR-1:0]   ack;
    logic [NR-1:0]   grant;
    logic            busy;
    logic            timeout;
    logic            trmt;
    logic [7:0]      tx_data;
    logic            tx_done;
    logic [2:0]      fsm_state;

    uart_tx_sched #(.NUM_REQ(NR), .TO_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / global limit ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- UART stub ----------------
    logic [7:0] sent_q[$];
    logic       hang = 1'b0;
    int         fix_len = 0;

    initial begin
        int cnt;
        logic pend;
        cnt = 0;
        pend = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                tx_done = 1'b0;
                cnt = 0;
                pend = 1'b0;
            end else if (trmt) begin
                // done from the previous frame stays visible during the trmt cycle
                sent_q.push_back(tx_data);
                pend = 1'b1;
            end else if (pend) begin
                pend = 1'b0;
                tx_done = 1'b0;
                cnt = hang ? 0 : ((fix_len > 0) ? fix_len : int'($urandom_range(1, 12)));
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_done = 1'b1;
            end
        end
    end

    // ---------------- reference model / monitor ----------------
    logic [7:0]    exp_q[$];
    logic [NR-1:0] ack_seen = '0;
    int            m_ptr = 0;
    int            m_owner = 0;
    int            m_wait = 0;
    logic          m_active = 1'b0;
    logic          m_send = 1'b0;
    logic          m_lo = 1'b0;
    logic [15:0]   m_word;
    logic [NR-1:0] m_oh;
    logic [7:0]    last_byte = 8'h00;
    logic [7:0]    exp_b;
    int            done_cnt = 0;
    int            m_ack_total = 0;
    int            m_bytes = 0;

    int            grant_log[$];
    int            gap_log[$];
    int            start_cnt = 0;
    int            obs_idle = 0;
    logic          prev_busy = 1'b0;
    int            obs_ack_cnt[NR];
    int            obs_ack_total = 0;
    int            obs_tmo = 0;

    function automatic int rr_pick(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++)
            if (r[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NR-1:0] g);
        int r;
        int n;
        r = -1;
        n = 0;
        for (int i = 0; i < NR; i++)
            if (g[i]) begin
                r = i;
                n++;
            end
        return (n == 1) ? r : -1;
    endfunction

    initial begin
        for (int i = 0; i < NR; i++) obs_ack_cnt[i] = 0;
        forever begin
            @(negedge clk);
            ack_seen = ack;
            for (int i = 0; i < NR; i++)
                if (ack[i]) begin
                    obs_ack_cnt[i]++;
                    obs_ack_total++;
                end
            if (timeout) obs_tmo++;
            if (!busy) obs_idle++;
            else if (trmt && !prev_busy) begin
                grant_log.push_back(oh_idx(grant));
                gap_log.push_back(obs_idle);
                obs_idle = 0;
                start_cnt++;
            end
            prev_busy = busy;

            if (!rst_n) begin
                check_eq("rst_busy", busy, 0);
                check_eq("rst_grant", grant, 0);
                check_eq("rst_ack", ack, 0);
                check_eq("rst_trmt", trmt, 0);
                check_eq("rst_timeout", timeout, 0);
                check_eq("rst_tx_data", tx_data, 8'h00);
                m_active = 1'b0;
                m_send = 1'b0;
                m_ptr = 0;
                last_byte = 8'h00;
                exp_q.delete();
            end else if (!m_active) begin
                check_eq("idle_busy", busy, 0);
                check_eq("idle_grant", grant, 0);
                check_eq("idle_trmt", trmt, 0);
                check_eq("idle_ack", ack, 0);
                check_eq("idle_timeout", timeout, 0);
                check_eq("idle_tx_data_hold", tx_data, last_byte);
                if (req != '0) begin
                    m_owner = rr_pick(req, m_ptr);
                    m_word = req_data[16*m_owner +: 16];
                    exp_q.push_back(m_word[15:8]);
                    exp_q.push_back(m_word[7:0]);
                    m_oh = '0;
                    m_oh[m_owner] = 1'b1;
                    m_active = 1'b1;
                    m_send = 1'b1;
                    m_lo = 1'b0;
                end
            end else begin
                check_eq("msg_busy", busy, 1);
                check_eq("msg_grant", grant, m_oh);
                if (m_send) begin
                    check_eq("send_trmt", trmt, 1);
                    exp_b = exp_q.pop_front();
                    check_eq(m_lo ? "send_lo_byte" : "send_hi_byte", tx_data, exp_b);
                    check_eq("send_ack", ack, 0);
                    check_eq("send_timeout", timeout, 0);
                    last_byte = exp_b;
                    m_bytes++;
                    m_send = 1'b0;
                    m_wait = 0;
                end else begin
                    check_eq("wait_trmt", trmt, 0);
                    check_eq("wait_tx_data_hold", tx_data, last_byte);
                    if (tx_done) begin
                        check_eq("done_timeout", timeout, 0);
                        if (!m_lo) begin
                            check_eq("hi_done_ack", ack, 0);
                            m_lo = 1'b1;
                            m_send = 1'b1;
                        end else begin
                            check_eq("lo_done_ack", ack, m_oh);
                            m_ack_total++;
                            m_active = 1'b0;
                            m_ptr = (m_owner + 1) % NR;
                            done_cnt++;
                        end
                    end else if (m_wait == TO - 1) begin
                        check_eq("wd_timeout", timeout, 1);
                        check_eq("wd_ack", ack, 0);
                        exp_q.delete();
                        m_active = 1'b0;
                        m_ptr = (m_owner + 1) % NR;
                        done_cnt++;
                    end else begin
                        check_eq("wait_ack", ack, 0);
                        check_eq("wait_timeout", timeout, 0);
                        m_wait++;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic auto_drop = 1'b1;

    task automatic step();
        @(posedge clk);
        #2;
        if (auto_drop) req = req & ~ack_seen;
    endtask

    task automatic set_word(input int i, input logic [15:0] w);
        req_data[16*i +: 16] = w;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_done(input int n, input int budget);
        int target;
        int k;
        target = done_cnt + n;
        k = 0;
        while (done_cnt < target && k < budget) begin
            step();
            k++;
        end
        check_eq("wait_done", done_cnt, target);
    endtask

    task automatic wait_start(input int n, input int budget);
        int target;
        int k;
        target = start_cnt + n;
        k = 0;
        while (start_cnt < target && k < budget) begin
            step();
            k++;
        end
        check_eq("wait_start", start_cnt, target);
    endtask

    task automatic wait_tmo(input int n, input int budget);
        int target;
        int k;
        target = obs_tmo + n;
        k = 0;
        while (obs_tmo < target && k < budget) begin
            step();
            k++;
        end
        check_eq("wait_timeout", obs_tmo, target);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base_g;
        int base_b;
        int base_a;
        int base_t;
        int k;

        rst_n = 1'b0;
        req = '0;
        req_data = '0;
        step();
        step();
        check_eq("reset_busy", busy, 0);
        check_eq("reset_trmt", trmt, 0);
        check_eq("reset_tx_data", tx_data, 8'h00);
        check_eq("reset_grant", grant, 0);
        rst_n = 1'b1;
        step();

        // single message from requester 2
        auto_drop = 1'b1;
        fix_len = 5;
        set_word(2, 16'hA55A);
        base_b = sent_q.size();
        req = 4'b0100;
        step();
        check_eq("t1_latency_trmt", trmt, 1);
        wait_done(1, 100);
        step();
        step();
        check_eq("t1_busy_after", busy, 0);
        check_eq("t1_ack_count", obs_ack_cnt[2], 1);
        check_eq("t1_nbytes", sent_q.size() - base_b, 2);
        check_eq("t1_hi_byte", sent_q[base_b], 8'hA5);
        check_eq("t1_lo_byte", sent_q[base_b+1], 8'h5A);

        // all four held: plain rotation from pointer 0
        do_reset();
        auto_drop = 1'b0;
        fix_len = 0;
        for (int i = 0; i < NR; i++) set_word(i, 16'h1234);
        base_g = grant_log.size();
        req = 4'b1111;
        wait_done(5, 500);
        req = '0;
        step();
        step();
        check_eq("t2_nmsg", grant_log.size() - base_g, 5);
        check_eq("t2_g0", grant_log[base_g], 0);
        check_eq("t2_g1", grant_log[base_g+1], 1);
        check_eq("t2_g2", grant_log[base_g+2], 2);
        check_eq("t2_g3", grant_log[base_g+3], 3);
        check_eq("t2_g4", grant_log[base_g+4], 0);
        for (int i = 1; i < 5; i++) check_eq("t2_idle_gap", gap_log[base_g+i], 1);

        // pointer at 2 after granting 1, then 0 and 1 both request: wrap to 0
        base_g = grant_log.size();
        req = 4'b0010;
        wait_start(1, 20);
        req = 4'b0011;
        wait_done(1, 100);
        wait_done(1, 100);
        req = '0;
        step();
        check_eq("t3_nmsg", grant_log.size() - base_g, 2);
        check_eq("t3_first", grant_log[base_g], 1);
        check_eq("t3_wrap", grant_log[base_g+1], 0);

        // watchdog abort: transmitter never reports done
        auto_drop = 1'b1;
        set_word(0, 16'h0F0F);
        set_word(1, 16'hC33C);
        hang = 1'b1;
        base_g = grant_log.size();
        base_t = obs_tmo;
        base_a = obs_ack_total;
        req = 4'b0011;
        wait_tmo(1, 33000);
        hang = 1'b0;
        check_eq("t4_timeouts", obs_tmo - base_t, 1);
        check_eq("t4_no_ack", obs_ack_total - base_a, 0);
        check_eq("t4_req1_kept", req[1], 1);
        wait_done(2, 200);
        check_eq("t4_nmsg", grant_log.size() - base_g, 3);
        check_eq("t4_aborted", grant_log[base_g], 1);
        check_eq("t4_next", grant_log[base_g+1], 0);
        check_eq("t4_retry", grant_log[base_g+2], 1);

        // requester drops req and changes data while the high byte is in flight
        fix_len = 6;
        set_word(1, 16'hBEEF);
        base_b = sent_q.size();
        base_a = obs_ack_cnt[1];
        req = 4'b0010;
        wait_start(1, 20);
        req[1] = 1'b0;
        set_word(1, 16'h1111);
        wait_done(1, 100);
        step();
        check_eq("t5_ack", obs_ack_cnt[1] - base_a, 1);
        check_eq("t5_nbytes", sent_q.size() - base_b, 2);
        check_eq("t5_hi_byte", sent_q[base_b], 8'hBE);
        check_eq("t5_lo_byte", sent_q[base_b+1], 8'hEF);

        // reset in the middle of the low byte wait
        set_word(2, 16'h7E81);
        set_word(0, 16'h3C5A);
        base_b = sent_q.size();
        req = 4'b0100;
        k = 0;
        while (sent_q.size() < base_b + 2 && k < 60) begin
            step();
            k++;
        end
        check_eq("t6_reach_lo", sent_q.size() - base_b, 2);
        step();
        rst_n = 1'b0;
        req = 4'b0101;
        #1;
        check_eq("t6_trmt", trmt, 0);
        check_eq("t6_grant", grant, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_ack", ack, 0);
        step();
        step();
        rst_n = 1'b1;
        base_g = grant_log.size();
        wait_done(2, 200);
        check_eq("t6_nmsg", grant_log.size() - base_g, 2);
        check_eq("t6_first", grant_log[base_g], 0);
        check_eq("t6_second", grant_log[base_g+1], 2);

        // randomized traffic
        fix_len = 0;
        auto_drop = 1'b1;
        step();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && $urandom_range(0, 5) == 0) begin
                    set_word(i, 16'($urandom()));
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 99) == 0) begin
                    req[i] = 1'b0;
                end else if (req[i] && $urandom_range(0, 29) == 0) begin
                    set_word(i, 16'($urandom()));
                end
            end
            step();
        end
        req = '0;
        k = 0;
        while (m_active && k < 100) begin
            step();
            k++;
        end
        step();
        step();
        check_eq("rand_drained", busy, 0);
        check_eq("rand_ack_total", obs_ack_total, m_ack_total);
        check_eq("rand_byte_total", sent_q.size(), m_bytes);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
